// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, one or two stop bits.
// state  | meaning
// IDLE   | line high, waiting for tx_start
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | parity bit (only when PARITY_EN=1)
// STOP   | STOP_BITS stop bits (high), tx_done on the final cycle
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_input,
  output logic       tx_pin,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_nxt;
  logic [7:0]        r_shift;
  logic [7:0]        w_shift_nxt;
  logic              r_parity;
  logic              w_parity_nxt;
  logic              r_pin;
  logic              w_pin_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_tick;

  assign w_tick = (r_baud == BAUD_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_pin     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_pin     <= w_pin_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = w_tick ? '0 : r_baud + 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;

    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (tx_start) begin
          w_state_nxt   = S_START;
          w_shift_nxt   = tx_input;
          w_parity_nxt  = (^tx_input) ^ (PARITY_ODD != 0);
          w_bit_idx_nxt = '0;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_nxt   = S_STOP;
          w_bit_idx_nxt = '0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_bit_idx == STOP_LAST) begin
            w_state_nxt   = S_IDLE;
            w_bit_idx_nxt = '0;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with it.
  always_comb begin
    w_pin_nxt  = 1'b1;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_STOP) && (w_baud_nxt == BAUD_MAX) &&
                 (w_bit_idx_nxt == STOP_LAST);
    case (w_state_nxt)
      S_START:  w_pin_nxt = 1'b0;
      S_DATA:   w_pin_nxt = w_shift_nxt[0];
      S_PARITY: w_pin_nxt = w_parity_nxt;
      default:  w_pin_nxt = 1'b1;
    endcase
  end

  assign tx_pin  = r_pin;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule
